// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder, time-shared across all bit positions by the controller.
module fa_cell (
  input  logic X,
  input  logic Y,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = X ^ Y ^ CI;
  assign CO = (X & Y) | (CI & (X ^ Y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell, one bit per cycle, LSB first.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  output logic [WIDTH-1:0] SUM,
  output logic             C_OUT,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s, fa_co;

  fa_cell u_fa (
    .X  (a_q[0]),
    .Y  (b_q[0]),
    .CI (carry_q),
    .S  (fa_s),
    .CO (fa_co)
  );

  // Next-state and datapath; subtraction is A + ~B + 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B ^ {WIDTH{SUB}};
          carry_d = SUB | C_IN;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        busy_d  = 1'b1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          c_out_d = fa_co;
          ovf_d   = carry_q ^ fa_co;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SUM   = sum_q;
  assign C_OUT = c_out_q;
  assign OVF   = ovf_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       SUB;
  logic [7:0] A;
  logic [7:0] B;
  logic       C_IN;
  logic [7:0] SUM;
  logic       C_OUT;
  logic       OVF;
  logic       BUSY;
  logic       DONE;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SUB   (SUB),
    .A     (A),
    .B     (B),
    .C_IN  (C_IN),
    .SUM   (SUM),
    .C_OUT (C_OUT),
    .OVF   (OVF),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Launch one operation, wait for DONE, check latency and results.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic cin,
                       input logic [7:0] exp_sum, input logic exp_c, input logic exp_v);
    int n;
    bit seen;
    A = a; B = b; SUB = sub; C_IN = cin; START = 1'b1;
    tick();
    START = 1'b0;
    A = 8'h00; B = 8'h00;
    check({tag, "_busy"}, 32'(BUSY), 32'd1);
    n = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      n++;
      if (DONE) seen = 1;
    end
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_sum"}, 32'(SUM), 32'(exp_sum));
    check({tag, "_cout"}, 32'(C_OUT), 32'(exp_c));
    check({tag, "_ovf"}, 32'(OVF), 32'(exp_v));
    check({tag, "_busy_fin"}, 32'(BUSY), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    tick();
    tick();
    check({tag, "_hold"}, {23'd0, OVF, C_OUT, SUM}, {23'd0, exp_v, exp_c, exp_sum});
  endtask

  initial begin
    int dones;
    int t_first;
    int t_second;
    RST = 1'b1; START = 1'b0; SUB = 1'b0; A = '0; B = '0; C_IN = 1'b0;
    tick();
    tick();
    check("reset_outs", {20'd0, DONE, BUSY, OVF, C_OUT, SUM}, 32'd0);
    RST = 1'b0;
    tick();

    do_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    do_op("add_7f_cin", 8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    do_op("sub_30_10", 8'h30, 8'h10, 1'b1, 1'b0, 8'h20, 1'b1, 1'b0);

    // START during RUN must be ignored.
    A = 8'h01; B = 8'h01; SUB = 1'b0; C_IN = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    A = 8'hAA; START = 1'b1;
    tick();
    START = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (DONE) dones++;
      tick();
    end
    check("ignore_start_dones", 32'(dones), 32'd1);
    check("ignore_start_sum", 32'(SUM), 32'h02);

    // Reset mid-operation abandons it.
    A = 8'h55; B = 8'h22; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    RST = 1'b1;
    #1;
    check("midrst_outs", {20'd0, DONE, BUSY, OVF, C_OUT, SUM}, 32'd0);
    tick();
    RST = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (DONE) dones++;
      tick();
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    do_op("after_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

    // START held high: back-to-back ops, period WIDTH+2.
    A = 8'h01; B = 8'h02; SUB = 1'b0; C_IN = 1'b0; START = 1'b1;
    t_first = -1;
    t_second = -1;
    for (int i = 0; i < 40 && t_second < 0; i++) begin
      tick();
      if (DONE) begin
        if (t_first < 0) t_first = i;
        else t_second = i;
      end
    end
    START = 1'b0;
    check("b2b_period", 32'(t_second - t_first), 32'd10);
    check("b2b_sum", 32'(SUM), 32'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous, active-high.
REQ-004 Port: START  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: SUB  input  1  0 = add, 1 = subtract (A - B); sampled with START.
REQ-006 Port: A  input  WIDTH  operand A; sampled with START.
REQ-007 Port: B  input  WIDTH  operand B; sampled with START.
REQ-008 Port: C_IN  input  1  carry-in for add; ignored when SUB=1.
REQ-009 Port: SUM  output  WIDTH  result, valid from DONE until next accepted START.
REQ-010 Port: C_OUT  output  1  carry-out of MSB (SUB=1: 1 = no borrow).
REQ-011 Port: OVF  output  1  signed overflow = carry into MSB XOR carry out of MSB.
REQ-012 Port: BUSY  output  1  high while an operation is in progress (RUN state).
REQ-013 Port: DONE  output  1  single-cycle pulse when SUM/C_OUT/OVF become valid.

Function
REQ-014 Block SHALL time-share one 1-bit full-adder cell, processing one bit per cycle, LSB first.
REQ-015 FSM states SHALL be IDLE, RUN, FIN; IDLE->RUN on START=1; RUN->FIN after WIDTH bit-cycles; FIN->IDLE unconditionally next cycle.
REQ-016 On START accepted at edge k: capture A, B^{WIDTH{SUB}}, carry = SUB ? 1 : C_IN; clear bit counter; BUSY=1 after edge k.
REQ-017 Bit i (0..WIDTH-1) SHALL be computed at edge k+1+i; sum bit shifted into SUM MSB side, operand registers shifted right, carry register updated.
REQ-018 At edge k+WIDTH state SHALL enter FIN: BUSY=0, DONE=1 for exactly one cycle, SUM/C_OUT/OVF final; latency START-to-DONE = WIDTH+1 edges.
REQ-019 SUM, C_OUT, OVF SHALL hold their final values through IDLE until the next accepted START, then may change freely while BUSY.
REQ-020 START while in RUN or FIN SHALL be ignored with no effect on the operation or operands; no queuing.
REQ-021 START held high continuously SHALL produce back-to-back operations, one accepted per IDLE visit (period WIDTH+2 cycles).
REQ-022 OVF SHALL be captured at the MSB bit-cycle as carry-in XOR carry-out of that cell.
REQ-023 Bit counter SHALL be ceil(log2(WIDTH)) bits wide; no wrap beyond WIDTH-1 is reachable.

Reset
REQ-024 RST=1 SHALL immediately force state IDLE, SUM=0, C_OUT=0, OVF=0, BUSY=0, DONE=0, operand/carry/counter registers 0.
REQ-025 RST asserted mid-operation SHALL abandon the operation with no DONE pulse; first START after RST deasserts runs normally.

Structure
REQ-026 Package serial_add_pkg SHALL hold the FSM state type (IDLE, RUN, FIN) and the default WIDTH constant.
REQ-027 The 1-bit adder SHALL be a sub-module fa_cell (inputs X, Y, CI; outputs S, CO), instantiated exactly once.

Verification (WIDTH=8)
REQ-028 A=8'h5A, B=8'h33, C_IN=0, SUB=0 -> DONE 9 edges after START, SUM=8'h8D, C_OUT=0, OVF=1.
REQ-029 A=8'hFF, B=8'h01, C_IN=0, SUB=0 -> SUM=8'h00, C_OUT=1, OVF=0.
REQ-030 A=8'h10, B=8'h20, SUB=1, C_IN=1 -> SUM=8'hF0, C_OUT=0, OVF=0 (C_IN ignored).
REQ-031 A=8'h7F, B=8'h00, C_IN=1, SUB=0 -> SUM=8'h80, C_OUT=0, OVF=1.
REQ-032 Start A=8'h01, B=8'h01; pulse START with A=8'hAA during RUN -> SUM=8'h02, single DONE, second START ignored.
REQ-033 RST pulsed at 4th RUN cycle -> all outputs 0 at once, no DONE; next START A=8'h03, B=8'h04 -> SUM=8'h07.
